// File: rtl/msg_sched.sv
// Message schedule expander: captures a padded message and streams the 64
// schedule words of each 512-bit block over a valid/ready handshake.
module msg_sched #(
  parameter int  NUM_BLOCKS = 2,
  localparam int BW         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [512*NUM_BLOCKS-1:0] msg,
  output logic                      busy,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [31:0]               w_data,
  output logic [5:0]                w_idx,
  output logic [BW-1:0]             w_blk,
  output logic                      w_last,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [BW-1:0] LAST_BLK = BW'(NUM_BLOCKS - 1);

  state_t                    state_q, state_d;
  logic [512*NUM_BLOCKS-1:0] msg_q, msg_d;
  logic [31:0]               win_q [16];
  logic [31:0]               win_d [16];
  logic [5:0]                t_q, t_d;
  logic [BW-1:0]             blk_q, blk_d;

  logic [511:0] blk_words [NUM_BLOCKS];
  logic [511:0] next_block;
  logic [31:0]  w_new;
  logic         accept;
  logic         last_word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
      assign blk_words[gi] = msg_q[512*(NUM_BLOCKS-gi)-1 -: 512];
    end
  endgenerate

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // win_q[k] holds W[t+k], so the new tail word is W[t+16].
  assign w_new     = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  assign accept    = (state_q == RUN) && w_ready;
  assign last_word = (t_q == 6'd63) && (blk_q == LAST_BLK);

  always_comb begin
    next_block = '0;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      if (b == int'(blk_q) + 1) next_block = blk_words[b];
    end
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    win_d   = win_q;
    t_d     = t_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          msg_d   = msg;
          t_d     = '0;
          blk_d   = '0;
          for (int i = 0; i < 16; i++) win_d[i] = msg[512*NUM_BLOCKS-1-32*i -: 32];
        end
      end
      RUN: begin
        if (accept) begin
          if (last_word) begin
            state_d = DONE;
          end else if (t_q == 6'd63) begin
            t_d   = '0;
            blk_d = blk_q + BW'(1);
            for (int i = 0; i < 16; i++) win_d[i] = next_block[511-32*i -: 32];
          end else begin
            t_d = t_q + 6'd1;
            for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
            win_d[15] = w_new;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      win_q   <= '{default: '0};
      t_q     <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      win_q   <= win_d;
      t_q     <= t_d;
      blk_q   <= blk_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign w_valid = (state_q == RUN);
  assign w_data  = win_q[0];
  assign w_idx   = t_q;
  assign w_blk   = blk_q;
  assign w_last  = w_valid && last_word;
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_msg_sched.sv
// Bench for msg_sched: one- and two-block instances checked against a
// full-array schedule model under random back-pressure, resets and start abuse.
module tb_msg_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_drv;
  logic          ready;
  int            sel;
  logic [511:0]  m1;
  logic [1023:0] m2;

  logic        a_start, a_busy, a_valid, a_last, a_done;
  logic [31:0] a_data;
  logic [5:0]  a_idx;
  logic [0:0]  a_blk;
  logic        b_start, b_busy, b_valid, b_last, b_done;
  logic [31:0] b_data;
  logic [5:0]  b_idx;
  logic [0:0]  b_blk;

  assign a_start = start_drv && (sel == 0);
  assign b_start = start_drv && (sel == 1);

  msg_sched #(.NUM_BLOCKS(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .msg(m1), .busy(a_busy),
    .w_valid(a_valid), .w_ready(ready), .w_data(a_data), .w_idx(a_idx),
    .w_blk(a_blk), .w_last(a_last), .done(a_done)
  );

  msg_sched #(.NUM_BLOCKS(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .msg(m2), .busy(b_busy),
    .w_valid(b_valid), .w_ready(ready), .w_data(b_data), .w_idx(b_idx),
    .w_blk(b_blk), .w_last(b_last), .done(b_done)
  );

  logic        o_busy, o_valid, o_last, o_done, o_blk;
  logic [31:0] o_data;
  logic [5:0]  o_idx;

  always_comb begin
    if (sel == 0) begin
      o_busy = a_busy; o_valid = a_valid; o_last = a_last; o_done = a_done;
      o_blk = a_blk[0]; o_data = a_data; o_idx = a_idx;
    end else begin
      o_busy = b_busy; o_valid = b_valid; o_last = b_last; o_done = b_done;
      o_blk = b_blk[0]; o_data = b_data; o_idx = b_idx;
    end
  end

  int          total = 0;
  int          bad = 0;
  int          last_busy;
  logic [31:0] exp_w [128];
  logic [31:0] got   [128];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: full 64-entry array per block, straight from the recurrence.
  task automatic build_exp(input logic [1023:0] m, input int nb);
    logic [31:0] w [64];
    for (int b = 0; b < nb; b++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = m[1023 - 512*b - 32*t -: 32];
        else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        exp_w[64*b + t] = w[t];
      end
    end
  endtask

  task automatic run(input int stall_pct, input bit pulse20, input bit keep_start);
    int          nwords, k, guard, busy_cyc;
    bit          stalled, pulsed;
    logic [31:0] sd;
    logic [5:0]  si;
    logic        sl, sb;
    nwords = 64 * (sel + 1);
    start_drv = 1'b1;
    step();
    check("busy_on", o_busy, 1);
    if (!keep_start) start_drv = 1'b0;
    k = 0; guard = 0; stalled = 0; pulsed = 0; busy_cyc = 1;
    sd = '0; si = '0; sl = 1'b0; sb = 1'b0;
    while (k < nwords && guard < 4000) begin
      if (stalled) begin
        check("hold_data", o_data, sd);
        check("hold_idx", o_idx, si);
        check("hold_last", o_last, sl);
        check("hold_blk", o_blk, sb);
      end
      check("valid", o_valid, 1);
      ready = ($urandom_range(99) >= stall_pct);
      if (pulse20 && !pulsed && o_idx == 6'd20) begin
        start_drv = 1'b1;
        m1 = ~m1;
        m2 = ~m2;
        pulsed = 1;
      end else if (!keep_start) begin
        start_drv = 1'b0;
      end
      if (ready) begin
        got[k] = o_data;
        check("data", o_data, exp_w[k]);
        check("idx", o_idx, 64'(k % 64));
        check("blk", o_blk, 64'(k / 64));
        check("last", o_last, 64'(k == nwords - 1));
        k++;
        stalled = 0;
      end else begin
        stalled = 1;
        sd = o_data; si = o_idx; sl = o_last; sb = o_blk;
      end
      step();
      guard++;
      if (o_busy) busy_cyc++;
    end
    check("timeout", 64'(guard < 4000), 1);
    if (!keep_start) start_drv = 1'b0;
    check("done_pulse", o_done, 1);
    check("valid_drop", o_valid, 0);
    check("busy_done", o_busy, 1);
    step();
    check("done_once", o_done, 0);
    check("busy_idle", o_busy, 0);
    check("valid_idle", o_valid, 0);
    last_busy = busy_cyc;
    $display("run nb=%0d stall=%0d words=%0d busy_cycles=%0d", sel + 1, stall_pct, k, busy_cyc);
  endtask

  initial begin
    rst = 1'b0; start_drv = 1'b0; ready = 1'b0; sel = 0; m1 = '0; m2 = '0;
    repeat (2) step();
    check("rst_a_busy", a_busy, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_data", a_data, 0);
    check("rst_b_done", b_done, 0);
    check("rst_b_idx", b_idx, 0);
    rst = 1'b1;
    step();

    // "abc" single block, full throughput, known answers
    m1 = {32'h61626380, 448'b0, 32'h00000018};
    build_exp({m1, 512'b0}, 1);
    run(0, 0, 0);
    check("busy_cycles_a", last_busy, 65);
    check("kat_w0", got[0], 32'h61626380);
    check("kat_w15", got[15], 32'h00000018);
    check("kat_w16", got[16], 32'h61626380);
    check("kat_w17", got[17], 32'h000F0000);
    check("kat_w18", got[18], 32'h7DA86405);
    check("kat_w19", got[19], 32'h600003C6);

    run(40, 0, 0);
    run(0, 1, 0);
    m1 = {32'h61626380, 448'b0, 32'h00000018};

    // two blocks, zero message
    sel = 1;
    m2 = '0;
    build_exp(m2, 2);
    run(0, 0, 0);
    check("busy_cycles_b", last_busy, 129);

    for (int i = 0; i < 32; i++) m2[32*i +: 32] = $urandom();
    build_exp(m2, 2);
    run(30, 0, 0);

    // asynchronous reset mid-run
    sel = 0;
    build_exp({m1, 512'b0}, 1);
    ready = 1'b1;
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    repeat (40) step();
    check("pre_rst_idx", o_idx, 40);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_valid", o_valid, 0);
    check("arst_last", o_last, 0);
    check("arst_done", o_done, 0);
    check("arst_data", o_data, 0);
    check("arst_idx", o_idx, 0);
    check("arst_blk", o_blk, 0);
    step();
    check("rst_hold_valid", o_valid, 0);
    rst = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_done", o_done, 0);
      check("post_rst_busy", o_busy, 0);
    end
    run(20, 0, 0);

    // start held high: back-to-back runs without overlap
    sel = 1;
    for (int i = 0; i < 32; i++) m2[32*i +: 32] = $urandom();
    build_exp(m2, 2);
    start_drv = 1'b1;
    run(0, 0, 1);
    run(25, 0, 1);
    start_drv = 1'b0;
    step();
    check("final_idle", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
